// File: rtl/fir4_seq_u.sv
// fir4_seq_u: 4-tap unsigned moving-sum FIR. A single (w+2)-bit adder is
// shared over four cycles to add the taps one at a time.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   flush      synchronous clear of tap history; aborts any operation
//   in_valid   producer offers sample a
//   in_ready   block accepts a sample this cycle (IDLE only)
//   a          unsigned input sample, w bits
//   out_valid  s holds a completed sum (HOLD)
//   out_ready  consumer takes s this cycle
//   s          registered sum of the last 4 accepted samples, w+2 bits
//   busy       high while in ACC or HOLD
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds its data stable until that edge. out_valid
// stays high and s stays stable until the consumer accepts.
//
// FSM observation: state is visible on outputs.
//   IDLE = {busy=0}, ACC = {busy=1, out_valid=0}, HOLD = {busy=1, out_valid=1}.
module fir4_seq_u #(
  parameter int w = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [w-1:0] a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [w+1:0] s,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t       state;
  logic [w-1:0] t0, t1, t2, t3;
  logic [w+1:0] acc;
  logic [1:0]   step;

  // Shared adder: acc plus the tap selected by step, zero-extended.
  logic [w-1:0] tap_sel;
  logic [w+1:0] sum;

  always_comb begin
    tap_sel = t0;
    case (step)
      2'd0: tap_sel = t0;
      2'd1: tap_sel = t1;
      2'd2: tap_sel = t2;
      2'd3: tap_sel = t3;
      default: tap_sel = t0;
    endcase
    sum = acc + {2'b00, tap_sel};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      t0        <= '0;
      t1        <= '0;
      t2        <= '0;
      t3        <= '0;
      acc       <= '0;
      step      <= 2'd0;
      s         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      // History is dropped but the last published sum s is kept.
      state     <= IDLE;
      t0        <= '0;
      t1        <= '0;
      t2        <= '0;
      t3        <= '0;
      acc       <= '0;
      step      <= 2'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            t0       <= a;
            t1       <= t0;
            t2       <= t1;
            t3       <= t2;
            acc      <= '0;
            step     <= 2'd0;
            state    <= ACC;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        ACC: begin
          acc  <= sum;
          step <= step + 2'd1;
          // The last tap goes straight into s, so step never wraps.
          if (step == 2'd3) begin
            s         <= sum;
            step      <= 2'd0;
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          // in_valid is ignored here. A sample offered together with
          // out_ready is taken in the following IDLE cycle.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir4_seq_u.sv
module tb_fir4_seq_u;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W+1:0] s;
  logic         busy;

  fir4_seq_u #(.w(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] hist_q[$];   // accepted samples, newest first
  logic [W+1:0] exp_q[$];    // expected sums awaiting publication

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Sum of the four most recent accepted samples; empty slots count as 0.
  function automatic logic [W+1:0] model_sum();
    int acc_i;
    acc_i = 0;
    foreach (hist_q[i]) acc_i += int'(hist_q[i]);
    return acc_i[W+1:0];
  endfunction

  task automatic model_accept(input logic [W-1:0] v);
    hist_q.push_front(v);
    if (hist_q.size() > 4) void'(hist_q.pop_back());
    exp_q.push_back(model_sum());
  endtask

  task automatic model_clear();
    hist_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a falling edge.

  // mode 0: consumer always ready
  // mode 1: consumer stalls 3 cycles while a stray sample 0x5 is offered
  // mode 2: consumer ready with 50% probability each cycle
  task automatic do_txn(input logic [W-1:0] val, input int mode,
                        output logic [W+1:0] got);
    int n;
    logic [W+1:0] held;
    logic [W+1:0] exp_s;
    got = '0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = val;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    model_accept(val);
    // Four edges of accumulation before out_valid rises.
    for (int i = 0; i < 4; i++) begin
      chk("latency_out_valid_low", int'(out_valid), 0);
      chk("busy_in_acc", int'(busy), 1);
      @(negedge clk);
    end
    chk("out_valid_after_4", int'(out_valid), 1);
    chk("in_ready_in_hold", int'(in_ready), 0);
    exp_s = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk("sum", int'(s), int'(exp_s));
    got  = s;
    held = s;
    if (mode == 1) begin
      in_valid = 1'b1;
      a        = 4'h5;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("stall_out_valid", int'(out_valid), 1);
        chk("stall_s_stable", int'(s), int'(held));
        chk("stall_in_ready", int'(in_ready), 0);
      end
      in_valid  = 1'b0;
      a         = val;
      out_ready = 1'b1;
      @(negedge clk);
    end else if (mode == 2) begin
      n = 0;
      out_ready = 1'($urandom_range(0, 1));
      while (!out_ready && n < 40) begin
        @(negedge clk);
        chk("rand_stall_out_valid", int'(out_valid), 1);
        chk("rand_stall_s_stable", int'(s), int'(held));
        out_ready = 1'($urandom_range(0, 1));
        n++;
      end
      out_ready = 1'b1;
      @(negedge clk);
    end else begin
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("out_valid_drops", int'(out_valid), 0);
    chk("s_kept_in_idle", int'(s), int'(held));
    chk("busy_idle", int'(busy), 0);
  endtask

  task automatic do_flush();
    flush    = 1'b1;
    in_valid = 1'b1;      // must not be accepted alongside flush
    a        = 4'hB;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    model_clear();
    chk("flush_busy", int'(busy), 0);
    chk("flush_out_valid", int'(out_valid), 0);
    chk("flush_in_ready", int'(in_ready), 1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic         flush_first;
    logic [W-1:0] a;
    logic [W+1:0] exp_s;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [W+1:0] got;
    logic [W+1:0] s_before;

    vecs[0] = '{1'b1, 4'h1, 6'h01};
    vecs[1] = '{1'b0, 4'h2, 6'h03};
    vecs[2] = '{1'b0, 4'h3, 6'h06};
    vecs[3] = '{1'b0, 4'h4, 6'h0A};
    vecs[4] = '{1'b1, 4'hF, 6'h0F};
    vecs[5] = '{1'b0, 4'hF, 6'h1E};
    vecs[6] = '{1'b0, 4'hF, 6'h2D};
    vecs[7] = '{1'b0, 4'hF, 6'h3C};

    // Reset state
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_s", int'(s), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);

    // Ramp and max-value tables
    foreach (vecs[i]) begin
      if (vecs[i].flush_first) do_flush();
      do_txn(vecs[i].a, 0, got);
      chk("table_sum", int'(got), int'(vecs[i].exp_s));
    end

    // Backpressure with stray in_valid during HOLD
    do_flush();
    do_txn(4'h1, 1, got);
    do_txn(4'h2, 0, got);
    chk("bp_no_stray", int'(got), 3);

    // Flush after 4,4,4,4 then send 2
    do_flush();
    for (int i = 0; i < 4; i++) do_txn(4'h4, 0, got);
    chk("flush_pre_sum", int'(got), 16);
    do_flush();
    do_txn(4'h2, 0, got);
    chk("flush_post_sum", int'(got), 2);

    // Flush in the middle of ACC: partial sum dropped, s kept
    s_before = s;
    in_valid = 1'b1;
    a        = 4'h3;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    do_flush();
    chk("flush_acc_s_kept", int'(s), int'(s_before));
    do_txn(4'h1, 0, got);
    chk("flush_acc_sum", int'(got), 1);

    // Async reset two cycles after an accept
    in_valid = 1'b1;
    a        = 4'h9;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("areset_s", int'(s), 0);
    chk("areset_out_valid", int'(out_valid), 0);
    chk("areset_busy", int'(busy), 0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("areset_in_ready", int'(in_ready), 1);
    do_txn(4'h7, 0, got);
    chk("areset_post_sum", int'(got), 7);

    // Randomised samples, random consumer readiness
    do_flush();
    for (int i = 0; i < 25; i++) begin
      do_txn(W'($urandom_range(0, (1 << W) - 1)), 2, got);
    end
    chk("exp_q_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir4_seq_u.md
Name: fir4_seq_u

Overview:
- Sequenced, resource-shared version of the 4-tap unsigned averaging FIR (sum of the last 4 samples).
- Instead of a 3-adder tree or cascade, one w+2-bit adder is time-multiplexed over 4 cycles under FSM control.
- Samples enter and sums leave through valid/ready handshakes, so the block can sit between streaming producers and consumers in the filter datapath.

Parameters:
- w, 4, input sample width in bits (unsigned); output width is w+2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of history; aborts any operation in progress.
- in_valid  input  1  producer has a sample on a.
- in_ready  output  1  block can accept a sample this cycle.
- a  input  w  unsigned input sample.
- out_valid  output  1  s holds a completed sum.
- out_ready  input  1  consumer accepts s this cycle.
- s  output  w+2  registered sum of the last 4 accepted samples.
- busy  output  1  high in ACC and HOLD.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; taps t0..t3=0; acc=0; step=0; s=0.
  - out_valid=0, busy=0; in_ready=1 once reset is released.
- FSM states IDLE, ACC, HOLD; all registers update on rising clk.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: t0<=a, t1<=t0, t2<=t1, t3<=t2; acc<=0; step<=0; go to ACC.
  - Without in_valid: stay in IDLE, nothing changes.
- ACC:
  - in_ready=0.
  - Each cycle: acc<=acc+t[step], zero-extended to w+2; step<=step+1.
  - On the cycle with step==3: s<=acc+t3 and go to HOLD.
- HOLD:
  - out_valid=1; s held stable.
  - On out_ready=1: go to IDLE; out_valid drops the next cycle.
- Timing:
  - Sample accepted at edge k → out_valid=1 after edge k+4 (4-cycle latency).
  - With out_ready tied high, the next accept is possible at edge k+6, i.e. one sample per 6 cycles.
- Arithmetic: 4·(2^w−1) < 2^(w+2), so no overflow or saturation; s is an exact unsigned sum.
- Function: s equals the sum of the 4 most recently accepted samples. Slots not yet filled since reset/flush count as 0.
- in_valid outside IDLE is ignored: the sample is not consumed, and taps are unchanged until the handshake completes. The producer must hold a.
- s changes only on ACC→HOLD. It keeps its last value in IDLE, with out_valid=0.
- flush=1 (highest priority, any state):
  - Next edge: taps=0, acc=0, step=0, state=IDLE.
  - s is not cleared; out_valid=0.
  - A simultaneous in_valid is not accepted.
- Reset asserted mid-ACC or mid-HOLD: all state and outputs clear immediately, without waiting for clk; the partial sum is discarded.
- step is 2 bits; it never wraps past 3, because the ACC exit is taken at step==3.
- Simultaneous out_ready and in_valid in HOLD: only the output handshake completes; the input is accepted in the following IDLE cycle.

Test Plan:
- Ramp, w=4: release reset, send 1,2,3,4 with out_ready=1 → s = 0x1,0x3,0x6,0xA; out_valid pulses once per sample, 4 cycles after each accept.
- Max value, w=4: send 0xF four times → s = 0x0F,0x1E,0x2D,0x3C; no wrap at 0x3C.
- Backpressure: hold out_ready=0 for 3 cycles in HOLD → out_valid stays 1, s stable, in_ready=0. Asserting in_valid with a=0x5 during that time has no effect on later sums.
- Flush: after samples 4,4,4,4 (s=0x10), flush for one cycle, then send 2 → s = 0x2, not 0x0E; busy=0 the cycle after flush.
- Async reset mid-ACC: drop reset between clock edges two cycles after an accept → s=0, out_valid=0, busy=0 immediately. After release, sending 7 → s=0x7.
- Random: 25 random samples, consumer ready randomly 50% of the time → every s matches a behavioural 4-deep shift-and-sum model of the accepted samples, with difference 0.
